// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file bus defines plus the types and default sizing used by the writeback arbiter.
// Include guards keep the defines harmless if another file in the same compile unit also provides them.
`ifndef REGFILE_WB_ARBITER_DEFINES
`define REGFILE_WB_ARBITER_DEFINES
`define RegAddrBus 4:0
`define RegBus 31:0
`define RstEnable 1'b1
`define WriteEnable 1'b1
`define ReadEnable 1'b1
`define ZeroWord 32'h0000_0000
`define WbArbFifoDepth 2
`define WbArbMaxPend 4
`endif

package regfile_wb_arbiter_pkg;
  localparam int WB_ARB_FIFO_DEPTH = `WbArbFifoDepth;
  localparam int WB_ARB_MAX_PEND   = `WbArbMaxPend;
  localparam int WB_ARB_STARVE_MAX = 8;

  typedef logic [`RegAddrBus] reg_addr_t;
  typedef logic [`RegBus]     reg_data_t;

  typedef struct packed {
    reg_addr_t waddr;
    reg_data_t wdata;
  } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Buffers long-latency results; a push becomes the head on the following cycle.
// No internal overflow or underflow protection: the caller gates push with !full and pop with !empty.
module wb_result_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  wb_entry_t i_push_dat,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output wb_entry_t o_head
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_cnt;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the RF write port: WB wins, buffered LU results drain into idle slots (zero-latency path).
// Stalls the pipeline on RAW hits against pending LU destinations and on prolonged LU starvation.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_ARB_FIFO_DEPTH,
  parameter int MAX_PEND   = WB_ARB_MAX_PEND,
  parameter int STARVE_MAX = WB_ARB_STARVE_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_we,
  input  logic [`RegAddrBus] wb_waddr,
  input  logic [`RegBus]     wb_wdata,
  input  logic               issue_valid,
  input  logic [`RegAddrBus] issue_waddr,
  output logic               issue_ready,
  input  logic               lu_valid,
  input  logic [`RegAddrBus] lu_waddr,
  input  logic [`RegBus]     lu_wdata,
  output logic               lu_ready,
  input  logic               re1,
  input  logic               re2,
  input  logic [`RegAddrBus] raddr1,
  input  logic [`RegAddrBus] raddr2,
  output logic               rf_we,
  output logic [`RegAddrBus] rf_waddr,
  output logic [`RegBus]     rf_wdata,
  output logic               stall_req
);
  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic      w_rst_act, w_full, w_empty, w_push, w_pop;
  logic      w_set, w_clr, w_haz1, w_haz2, w_starve;
  wb_entry_t w_head, w_lu_entry;

  logic [31:0]   r_pending;
  logic [PW-1:0] r_pend_cnt;
  logic [SW-1:0] r_starve_cnt;

  assign w_rst_act  = (rst == `RstEnable);
  assign w_lu_entry = {lu_waddr, lu_wdata};
  assign w_push     = !w_rst_act && lu_valid && !w_full;
  assign w_pop      = !w_rst_act && (wb_we != `WriteEnable) && !w_empty;

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_lu_entry),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head)
  );

  // A head destined for $0 still consumes the slot, it just never asserts the write.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = `ZeroWord;
    if (!w_rst_act) begin
      if (wb_we == `WriteEnable) begin
        rf_we    = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end else if (!w_empty) begin
        rf_we    = (w_head.waddr != '0);
        rf_waddr = w_head.waddr;
        rf_wdata = w_head.wdata;
      end
    end
  end

  assign lu_ready    = !w_rst_act && !w_full;
  assign issue_ready = !w_rst_act && (r_pend_cnt < PW'(MAX_PEND)) && !r_pending[issue_waddr];
  assign w_set       = issue_valid && issue_ready && (issue_waddr != '0);
  assign w_clr       = w_pop && r_pending[w_head.waddr];

  always_ff @(posedge clk) begin
    if (w_rst_act) begin
      r_pending  <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_set) r_pending[issue_waddr]   <= 1'b1;
      if (w_clr) r_pending[w_head.waddr] <= 1'b0;
      case ({w_set, w_clr})
        2'b10:   r_pend_cnt <= r_pend_cnt + PW'(1);
        2'b01:   r_pend_cnt <= r_pend_cnt - PW'(1);
        default: r_pend_cnt <= r_pend_cnt;
      endcase
    end
  end

  // The RF forwards a same-cycle write, so a popping head satisfies a matching read.
  assign w_haz1 = (re1 == `ReadEnable) && (raddr1 != '0) && r_pending[raddr1]
                  && !(w_pop && (w_head.waddr == raddr1));
  assign w_haz2 = (re2 == `ReadEnable) && (raddr2 != '0) && r_pending[raddr2]
                  && !(w_pop && (w_head.waddr == raddr2));

  always_ff @(posedge clk) begin
    if (w_rst_act || w_empty || w_pop) begin
      r_starve_cnt <= '0;
    end else if (wb_we && (r_starve_cnt != SW'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  assign w_starve  = (r_starve_cnt == SW'(STARVE_MAX));
  assign stall_req = !w_rst_act && (w_haz1 || w_haz2 || w_starve);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change on the falling edge, outputs are checked 1ns later.
module tb_regfile_wb_arbiter;
  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic        issue_ready;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;

  int n_checks;
  int n_fail;
  logic [31:0] m_pend;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .wb_we       (wb_we),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .issue_ready (issue_ready),
    .lu_valid    (lu_valid),
    .lu_waddr    (lu_waddr),
    .lu_wdata    (lu_wdata),
    .lu_ready    (lu_ready),
    .re1         (re1),
    .re2         (re2),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .stall_req   (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // WB must never target a register with an outstanding LU result.
  always @(posedge clk) begin
    if (rst) begin
      m_pend <= '0;
    end else begin
      assert (!(wb_we && wb_waddr != 5'd0 && m_pend[wb_waddr]))
        else $error("FAIL wb_precond got=wb to pending $%0d exp=non-pending", wb_waddr);
      if (issue_valid && issue_ready && issue_waddr != 5'd0) m_pend[issue_waddr] <= 1'b1;
      if (!wb_we && rf_we) m_pend[rf_waddr] <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    issue_valid = 1'b0; issue_waddr = '0;
    lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
    re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1'b1;
    issue_waddr = a;
  endtask

  task automatic lu_push(input logic [4:0] a, input logic [31:0] d);
    lu_valid = 1'b1;
    lu_waddr = a;
    lu_wdata = d;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we    = 1'b1;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset with every request active: outputs must stay quiet.
    idle();
    rst = 1'b1;
    wb(5'd3, 32'hDEAD_0003);
    lu_push(5'd6, 32'h66);
    issue(5'd6);
    re1 = 1'b1; raddr1 = 5'd6;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("rst_rf_we", rf_we, 0);
      check("rst_rf_waddr", rf_waddr, 0);
      check("rst_rf_wdata", rf_wdata, 0);
      check("rst_issue_ready", issue_ready, 0);
      check("rst_lu_ready", lu_ready, 0);
      check("rst_stall", stall_req, 0);
    end
    rst = 1'b0;
    idle();
    #1;
    check("post_rst_lu_ready", lu_ready, 1);
    check("post_rst_issue_ready", issue_ready, 1);
    check("post_rst_rf_we", rf_we, 0);
    check("post_rst_stall", stall_req, 0);

    // Idle drain of $5.
    step(); issue(5'd5); #1;
    check("drain_issue_ready", issue_ready, 1);
    step(); lu_push(5'd5, 32'h1234_5678); re1 = 1'b1; raddr1 = 5'd5; #1;
    check("drain_push_rf_we", rf_we, 0);
    check("drain_pend_stall", stall_req, 1);
    check("drain_lu_ready", lu_ready, 1);
    step(); re1 = 1'b1; raddr1 = 5'd5; #1;
    check("drain_rf_we", rf_we, 1);
    check("drain_rf_waddr", rf_waddr, 5);
    check("drain_rf_wdata", rf_wdata, 32'h1234_5678);
    check("drain_bypass_stall", stall_req, 0);
    step(); re1 = 1'b1; raddr1 = 5'd5; issue_waddr = 5'd5; #1;
    check("drain_cleared_stall", stall_req, 0);
    check("drain_cleared_ready", issue_ready, 1);
    check("drain_idle_rf_we", rf_we, 0);

    // WB priority while the FIFO fills.
    step(); issue(5'd7); #1;
    check("prio_issue7", issue_ready, 1);
    step(); issue(5'd8); #1;
    check("prio_issue8", issue_ready, 1);
    step(); wb(5'd3, 32'hAAAA_0003); lu_push(5'd7, 32'h77); #1;
    check("prio_rf_we", rf_we, 1);
    check("prio_rf_waddr", rf_waddr, 3);
    check("prio_rf_wdata", rf_wdata, 32'hAAAA_0003);
    check("prio_lu_ready0", lu_ready, 1);
    step(); wb(5'd3, 32'hAAAA_0003); lu_push(5'd8, 32'h88); #1;
    check("prio_wb_keeps_port", rf_waddr, 3);
    check("prio_lu_ready1", lu_ready, 1);
    step(); wb(5'd3, 32'hAAAA_0003); lu_push(5'd9, 32'h99); #1;
    check("prio_full", lu_ready, 0);
    check("prio_full_rf_wdata", rf_wdata, 32'hAAAA_0003);
    step(); lu_push(5'd9, 32'h99); #1;
    check("prio_pop7_we", rf_we, 1);
    check("prio_pop7_waddr", rf_waddr, 7);
    check("prio_pop7_wdata", rf_wdata, 32'h77);
    check("prio_full_no_push", lu_ready, 0);
    step(); #1;
    check("prio_pop8_we", rf_we, 1);
    check("prio_pop8_waddr", rf_waddr, 8);
    check("prio_pop8_wdata", rf_wdata, 32'h88);
    check("prio_lu_ready_again", lu_ready, 1);
    step(); #1;
    check("prio_empty", rf_we, 0);

    // RAW hazard on $9.
    step(); issue(5'd9); #1;
    check("raw_issue", issue_ready, 1);
    step(); re1 = 1'b1; raddr1 = 5'd9; #1;
    check("raw_re1", stall_req, 1);
    step(); raddr1 = 5'd9; #1;
    check("raw_re1_off", stall_req, 0);
    step(); re2 = 1'b1; raddr2 = 5'd9; #1;
    check("raw_re2", stall_req, 1);
    step(); re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd8; #1;
    check("raw_zero_and_free", stall_req, 0);
    step(); re1 = 1'b1; raddr1 = 5'd9; lu_push(5'd9, 32'h9999); #1;
    check("raw_push_cycle", stall_req, 1);
    step(); re1 = 1'b1; raddr1 = 5'd9; wb(5'd3, 32'h3); #1;
    check("raw_blocked_pop", stall_req, 1);
    step(); re1 = 1'b1; raddr1 = 5'd9; #1;
    check("raw_pop_bypass", stall_req, 0);
    check("raw_pop_waddr", rf_waddr, 9);
    check("raw_pop_wdata", rf_wdata, 32'h9999);
    step(); re1 = 1'b1; raddr1 = 5'd9; #1;
    check("raw_after_pop", stall_req, 0);

    // Starvation of a single buffered $10 result.
    step(); issue(5'd10); #1;
    step(); wb(5'd3, 32'h3); lu_push(5'd10, 32'hA); #1;
    check("starve_push", stall_req, 0);
    for (int i = 0; i < 8; i++) begin
      step(); wb(5'd3, 32'h3); #1;
      check("starve_counting", stall_req, 0);
    end
    step(); wb(5'd3, 32'h3); #1;
    check("starve_raised", stall_req, 1);
    check("starve_wb_owns", rf_waddr, 3);
    step(); #1;
    check("starve_pop_cycle", stall_req, 1);
    check("starve_pop_waddr", rf_waddr, 10);
    check("starve_pop_we", rf_we, 1);
    step(); #1;
    check("starve_cleared", stall_req, 0);

    // Scoreboard limits.
    step(); issue(5'd4); #1;
    check("lim_issue4", issue_ready, 1);
    step(); issue(5'd4); #1;
    check("lim_waw", issue_ready, 0);
    step(); issue(5'd11); #1;
    check("lim_issue11", issue_ready, 1);
    step(); issue(5'd12); #1;
    check("lim_issue12", issue_ready, 1);
    step(); issue(5'd0); #1;
    check("lim_issue0", issue_ready, 1);
    step(); issue(5'd13); #1;
    check("lim_issue13_after_0", issue_ready, 1);
    step(); issue(5'd14); #1;
    check("lim_max", issue_ready, 0);
    step(); issue(5'd14); lu_push(5'd4, 32'h44); #1;
    check("lim_max_push", issue_ready, 0);
    step(); issue(5'd14); #1;
    check("lim_pop4_waddr", rf_waddr, 4);
    check("lim_max_pop_cycle", issue_ready, 0);
    step(); issue(5'd14); #1;
    check("lim_after_pop", issue_ready, 1);

    // Reset mid-operation drops buffered results and pending marks.
    step(); lu_push(5'd11, 32'hB); #1;
    check("mid_push", lu_ready, 1);
    step(); rst = 1'b1; #1;
    check("mid_rst_rf_we", rf_we, 0);
    check("mid_rst_issue_ready", issue_ready, 0);
    step(); rst = 1'b0; re1 = 1'b1; raddr1 = 5'd12; issue_waddr = 5'd12; #1;
    check("mid_fifo_flushed", rf_we, 0);
    check("mid_pend_flushed", stall_req, 0);
    check("mid_ready", issue_ready, 1);

    step(); #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback (WB) and one long-latency unit (LU, e.g. divider).
- WB has absolute priority. LU results are buffered in a small FIFO and drained into idle write slots.
- Holds a pending-destination scoreboard for issued LU ops. Raises stall_req to the pipeline controller on RAW hazards and on LU starvation.
- Sits between MEM/WB, the LU, the ID stage and the register file write port.

Parameters:
- FIFO_DEPTH, 2, LU result buffer entries (power of 2, >=2).
- MAX_PEND, 4, maximum outstanding issued LU ops.
- STARVE_MAX, 8, consecutive WB-blocked cycles with a non-empty FIFO before a forced stall.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- wb_we  in  1  pipeline writeback enable
- wb_waddr  in  5  writeback destination
- wb_wdata  in  32  writeback data
- issue_valid  in  1  LU op issued with a destination
- issue_waddr  in  5  LU op destination
- issue_ready  out  1  issue accepted this cycle
- lu_valid  in  1  LU result valid
- lu_waddr  in  5  LU result destination
- lu_wdata  in  32  LU result data
- lu_ready  out  1  FIFO can accept a result
- re1, re2  in  1  ID read enables
- raddr1, raddr2  in  5  ID read addresses
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data
- stall_req  out  1  stall request to the pipeline controller

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied, pending vector and count cleared, starvation counter = 0.
  - While rst=1: rf_we=0, rf_waddr=0, rf_wdata=0, issue_ready=0, lu_ready=0, stall_req=0.
  - Reset mid-operation discards buffered results and pending marks.
- Write port (combinational, zero latency):
  - wb_we=1: rf_* = wb_*.
  - Else, FIFO non-empty: rf_* = head; pop at the clk edge. rf_we=0 if head waddr=0; the entry is still popped.
  - Else: rf_we=0.
- LU acceptance:
  - lu_ready = !full.
  - Push on lu_valid & lu_ready; the entry is visible as head no earlier than the next cycle.
  - Push and pop in the same cycle when full is not allowed, because lu_ready is low when full.
  - Push and pop in the same cycle when not full: count unchanged.
- Scoreboard:
  - pending[31:0] plus a count.
  - issue_ready = pend_cnt<MAX_PEND && !pending[issue_waddr]. The WAW guard blocks re-issue to a pending register.
  - Accepted issue with issue_waddr!=0 sets pending and count++. Issue to $0 is accepted but not tracked.
  - A FIFO pop clears pending[head waddr] and count--.
  - Set and clear of the same register in one cycle cannot occur, because of the WAW guard.
  - Set and clear of different registers in one cycle: count unchanged.
- Hazard stall:
  - For each read port k, hazard_k = re_k & raddr_k!=0 & pending[raddr_k].
  - hazard_k is suppressed when a pop this cycle writes raddr_k, since the register file bypasses same-cycle writes.
- Starvation:
  - Counter increments on a cycle with FIFO non-empty and wb_we=1. It clears on any pop or when the FIFO is empty.
  - When counter==STARVE_MAX, starve=1 until the next pop.
- stall_req = hazard_1 | hazard_2 | starve.
- Precondition: WB never writes a pending register. Bench asserts this; RTL does not check.

Decomposition:
- Reuse the shared defines include: RegAddrBus, RegBus, RstEnable, WriteEnable, ReadEnable, ZeroWord. Add WbArbFifoDepth and WbArbMaxPend there.
- One sub-module, wb_result_fifo: synchronous FIFO with {waddr, wdata}, push, pop, full, empty, head.
- Scoreboard, arbitration and starvation logic stay in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles with lu_valid=1 and issue_valid=1 -> all outputs 0, nothing written; after release, lu_ready=1 and issue_ready=1.
- Idle drain: issue $5; LU returns $5=0x1234_5678 with wb_we=0 -> rf_we=1, rf_waddr=5, rf_wdata=0x12345678 one cycle after the push; pending[5] cleared after that edge.
- Priority: WB writes $3 every cycle while LU pushes $7 -> WB owns the port; $7 is written in the first cycle with wb_we=0, and the FIFO fills (lu_ready=0) after FIFO_DEPTH pushes.
- RAW stall: $9 pending, ID re1=1 raddr1=9 -> stall_req=1; it drops in the cycle $9 pops (bypass); raddr=0 or re=0 -> no stall.
- Starvation: FIFO non-empty with wb_we held 1 -> stall_req rises after 8 blocked cycles and falls the cycle after wb_we=0 lets the head pop.
- Limits: issue $4 twice -> second issue_ready=0 (WAW); issue 4 distinct registers -> 5th blocked until a pop; issue $0 -> accepted, pend count unchanged.
